// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation sequencer: ALU ctrl codes,
// ALUOp encodings, R-type funct codes and the sequencer FSM states.
package alu_pkg;

    // 3-bit ctrl codes understood by the registered ALU
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b111;
    localparam logic [2:0] ALU_PASS = 3'b011;

    // ALUOp field of an operation request
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp + funct into the ALU ctrl code, an
// unsupported-funct error flag and an add/sub (carry-producing) flag.
module alu_ctrl_decode (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] ctrl,
    output logic       err,
    output logic       is_arith
);
    import alu_pkg::*;

    // Unsupported funct falls back to pass-through so the result is operand A
    always_comb begin
        ctrl     = ALU_PASS;
        err      = 1'b0;
        is_arith = 1'b0;
        case (aluop)
            ALUOP_ADD: begin
                ctrl     = ALU_ADD;
                is_arith = 1'b1;
            end
            ALUOP_SUB: begin
                ctrl     = ALU_SUB;
                is_arith = 1'b1;
            end
            ALUOP_OR: ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: begin
                        ctrl     = ALU_ADD;
                        is_arith = 1'b1;
                    end
                    FUNCT_SUB: begin
                        ctrl     = ALU_SUB;
                        is_arith = 1'b1;
                    end
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_XOR: ctrl = ALU_XOR;
                    default:   err  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the registered ALU: accepts one request at a time, drives
// the ALU, waits out its latency, then holds the captured result until the
// consumer takes it.
module alu_op_sequencer #(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_err
);
    import alu_pkg::*;

    localparam int CW = $clog2(ALU_LATENCY + 1);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          err_q, arith_q;
    logic [2:0]    dec_ctrl;
    logic          dec_err, dec_arith;
    logic          accept, capture, res_take;

    alu_ctrl_decode u_decode (
        .aluop    (req_aluop),
        .funct    (req_funct),
        .ctrl     (dec_ctrl),
        .err      (dec_err),
        .is_arith (dec_arith)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)   state_nxt = ST_BUSY;
                ST_BUSY: if (capture)  state_nxt = ST_DONE;
                ST_DONE: if (res_take) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs and the per-state strobes used by the datapath
    always_comb begin
        req_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        res_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid & ~flush;
            end
            ST_BUSY: capture = (cnt == '0) & ~flush;
            ST_DONE: begin
                res_valid = 1'b1;
                res_take  = res_ready & ~flush;
            end
            default: ;
        endcase
    end

    // ALU drive, latency counter and result capture; flush leaves res_* intact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_ctrl  <= ALU_PASS;
            cnt       <= '0;
            err_q     <= 1'b0;
            arith_q   <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else if (flush) begin
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_ctrl  <= ALU_PASS;
            cnt       <= '0;
        end else begin
            if (accept) begin
                alu_data1 <= req_a;
                alu_data2 <= req_b;
                alu_ctrl  <= dec_ctrl;
                err_q     <= dec_err;
                arith_q   <= dec_arith;
                cnt       <= CW'(ALU_LATENCY);
            end
            if (state == ST_BUSY && !capture) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                res_data  <= alu_out;
                res_carry <= alu_carry & arith_q;
                res_zero  <= (alu_out == '0);
                res_err   <= err_q;
            end
            if (res_take) begin
                alu_data1 <= '0;
                alu_data2 <= '0;
                alu_ctrl  <= ALU_PASS;
            end
        end
    end

endmodule
